// File: rtl/load_store_unit_pkg.sv
// Shared types and constants for the load/store unit.
// Size codes, funct3 values, FSM states and size helper.
package lsu_pkg;

  localparam logic [31:0] BASE_ADDR = 32'h0100_0000;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    BYTES,
    RESP
  } state_e;

  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SIZE_BYTE: return 3'd1;
      SIZE_HALF: return 3'd2;
      default:   return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Execute-side request/response bundle and data-memory port.
// master drives requests (execute) or the memory port (LSU).
interface lsu_req_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_fault;

  modport master (
    output req_valid, req_store, req_funct3,
    output req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid,
    input  resp_rdata, resp_fault
  );

  modport slave (
    input  req_valid, req_store, req_funct3,
    input  req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid,
    output resp_rdata, resp_fault
  );
endinterface

interface lsu_mem_if;
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic        mem_read_write;
  logic [2:0]  mem_access_size;
  logic [31:0] mem_data_out;

  modport master (
    output mem_address, mem_data_in,
    output mem_read_write, mem_access_size,
    input  mem_data_out
  );

  modport slave (
    input  mem_address, mem_data_in,
    input  mem_read_write, mem_access_size,
    output mem_data_out
  );
endinterface

// File: rtl/load_store_unit_extend.sv
// Sign/zero extender for byte-assembled load data.
// Word passes through; byte/half extend unless unsigned.
module lsu_extend
  import lsu_pkg::*;
(
  input  logic [31:0] raw_i,
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  output logic [31:0] data_o
);

  logic sb;
  logic sh;

  assign sb = ~uns_i & raw_i[7];
  assign sh = ~uns_i & raw_i[15];

  always_comb begin
    data_o = raw_i;
    unique case (1'b1)
      (size_i == SIZE_BYTE):
        data_o = {{24{sb}}, raw_i[7:0]};
      (size_i == SIZE_HALF):
        data_o = {{16{sh}}, raw_i[15:0]};
      default:
        data_o = raw_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: aligned single access or byte-split
// misaligned access, with registered response and fault flag.
module load_store_unit #(
  parameter logic [31:0] BASE_ADDR        = lsu_pkg::BASE_ADDR,
  parameter int unsigned MEM_DEPTH        = 1048576,
  parameter bit          ALLOW_MISALIGNED = 1'b1
) (
  input  logic      clock,
  input  logic      reset,
  lsu_req_if.slave  req,
  lsu_mem_if.master mem
);
  import lsu_pkg::*;

  localparam logic [32:0] LO = {1'b0, BASE_ADDR};
  localparam logic [32:0] HI =
    {1'b0, BASE_ADDR} + 33'(MEM_DEPTH) - 33'd1;
  localparam logic [2:0] ACC_BYTE = 3'b100;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  f3_q, f3_d;
  logic        store_q, store_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] asm_q, asm_d;
  logic        rv_q, rv_d;
  logic [31:0] rd_q, rd_d;
  logic        rf_q, rf_d;
  logic [31:0] maddr_q, maddr_d;
  logic [31:0] mdata_q, mdata_d;
  logic [2:0]  msize_q, msize_d;

  logic [31:0] m_addr;
  logic [31:0] m_data;
  logic [2:0]  m_size;
  logic        m_we;

  logic [1:0]  sz;
  logic [32:0] last;
  logic        illegal;
  logic        mis;
  logic        oor;
  logic        fault;

  logic [31:0] asm_nxt;
  logic [31:0] ext_data;
  logic [7:0]  wbyte;
  logic        byte_last;

  assign sz = req.req_funct3[1:0];

  always_comb begin
    illegal = (sz == 2'b11)
            | (req.req_store & req.req_funct3[2])
            | (~req.req_store & req.req_funct3[2]
               & (sz == SIZE_WORD));
    mis = ((sz == SIZE_HALF) & req.req_addr[0])
        | ((sz == SIZE_WORD) & (req.req_addr[1:0] != 2'b00));
    // 33-bit end address so a window at the top cannot wrap
    last = {1'b0, req.req_addr}
         + {30'b0, size_bytes(sz)} - 33'd1;
    oor = ({1'b0, req.req_addr} < LO) | (last > HI);
    fault = illegal | oor | (mis & ~ALLOW_MISALIGNED);
  end

  always_comb begin
    asm_nxt = asm_q;
    asm_nxt[{cnt_q, 3'b000} +: 8] = mem.mem_data_out[7:0];
  end

  assign wbyte = wdata_q[{cnt_q, 3'b000} +: 8];
  assign byte_last = (f3_q[1:0] == SIZE_HALF)
                   ? (cnt_q == 2'd1)
                   : (cnt_q == 2'd3);

  lsu_extend u_ext (
    .raw_i  (asm_nxt),
    .size_i (f3_q[1:0]),
    .uns_i  (f3_q[2]),
    .data_o (ext_data)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    store_d = store_q;
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    rv_d    = rv_q;
    rd_d    = rd_q;
    rf_d    = rf_q;
    m_addr  = maddr_q;
    m_size  = msize_q;
    m_data  = mdata_q;
    m_we    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req.req_valid) begin
          addr_d  = req.req_addr;
          wdata_d = req.req_wdata;
          f3_d    = req.req_funct3;
          store_d = req.req_store;
          cnt_d   = '0;
          asm_d   = '0;
          if (fault) begin
            state_d = RESP;
            rv_d    = 1'b1;
            rd_d    = '0;
            rf_d    = 1'b1;
          end else if (mis) begin
            state_d = BYTES;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        m_addr  = addr_q;
        m_size  = f3_q;
        m_data  = wdata_q;
        m_we    = store_q;
        rd_d    = store_q ? '0 : mem.mem_data_out;
        rf_d    = 1'b0;
        rv_d    = 1'b1;
        state_d = RESP;
      end
      BYTES: begin
        m_addr = addr_q + {30'b0, cnt_q};
        m_size = ACC_BYTE;
        m_data = {24'b0, wbyte};
        m_we   = store_q;
        asm_d  = asm_nxt;
        cnt_d  = cnt_q + 2'd1;
        if (byte_last) begin
          state_d = RESP;
          rv_d    = 1'b1;
          rf_d    = 1'b0;
          rd_d    = store_q ? '0 : ext_data;
        end
      end
      RESP: begin
        if (req.resp_ready) begin
          rv_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    maddr_d = m_addr;
    msize_d = m_size;
    mdata_d = m_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      store_q <= 1'b0;
      cnt_q   <= '0;
      asm_q   <= '0;
      rv_q    <= 1'b0;
      rd_q    <= '0;
      rf_q    <= 1'b0;
      maddr_q <= BASE_ADDR;
      mdata_q <= '0;
      msize_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      store_q <= store_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      rv_q    <= rv_d;
      rd_q    <= rd_d;
      rf_q    <= rf_d;
      maddr_q <= maddr_d;
      mdata_q <= mdata_d;
      msize_q <= msize_d;
    end
  end

  // a reset cycle must never commit a write, even mid-split
  assign mem.mem_read_write  = m_we & ~reset;
  assign mem.mem_address     = m_addr;
  assign mem.mem_access_size = m_size;
  assign mem.mem_data_in     = m_data;

  assign req.req_ready  = (state_q == IDLE);
  assign req.resp_valid = rv_q;
  assign req.resp_rdata = rd_q;
  assign req.resp_fault = rf_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a byte memory model.
// Stimulus queues expected responses; a negedge monitor checks.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam logic [31:0] BASE  = 32'h0100_0000;
  localparam int unsigned DEPTH = 1048576;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          lat;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  lsu_req_if req ();
  lsu_mem_if mem ();

  load_store_unit #(
    .BASE_ADDR        (BASE),
    .MEM_DEPTH        (DEPTH),
    .ALLOW_MISALIGNED (1'b1)
  ) dut (
    .clock (clock),
    .reset (reset),
    .req   (req),
    .mem   (mem)
  );

  logic [7:0]  ram [0:255];
  logic        clr = 1'b1;
  logic        poke_en = 1'b0;
  logic [7:0]  poke_i = '0;
  logic [7:0]  poke_v = '0;
  logic [31:0] rd_raw;
  logic [31:0] wa;
  logic [31:0] wo;

  int   tests = 0;
  int   fails = 0;
  int   done_cnt = 0;
  int   wr_cnt = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   rise_cyc = 0;
  logic prev_v = 1'b0;
  exp_t q[$];
  exp_t me;

  function automatic logic [7:0] rb(input logic [31:0] a);
    logic [31:0] o;
    o = a - BASE;
    if (a >= BASE && o < 32'd256) return ram[o[7:0]];
    return 8'h00;
  endfunction

  always_comb begin
    rd_raw = {rb(mem.mem_address + 32'd3), rb(mem.mem_address + 32'd2),
              rb(mem.mem_address + 32'd1), rb(mem.mem_address)};
    case (mem.mem_access_size)
      3'b000:  mem.mem_data_out = {{24{rd_raw[7]}}, rd_raw[7:0]};
      3'b100:  mem.mem_data_out = {24'b0, rd_raw[7:0]};
      3'b001:  mem.mem_data_out = {{16{rd_raw[15]}}, rd_raw[15:0]};
      3'b101:  mem.mem_data_out = {16'b0, rd_raw[15:0]};
      default: mem.mem_data_out = rd_raw;
    endcase
  end

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (clr) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
    end else if (poke_en) begin
      ram[poke_i] <= poke_v;
    end else if (mem.mem_read_write) begin
      wr_cnt <= wr_cnt + 1;
      for (int b = 0; b < 4; b++) begin
        wa = mem.mem_address + 32'(b);
        wo = wa - BASE;
        if ((b == 0 || (b == 1 && mem.mem_access_size[1:0] != 2'b00)
             || mem.mem_access_size[1:0] == 2'b10)
            && wa >= BASE && wo < 32'd256)
          ram[wo[7:0]] <= mem.mem_data_in[8*b +: 8];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (req.req_valid && req.req_ready) acc_cyc = cyc;
    if (req.resp_valid && !prev_v) rise_cyc = cyc;
    prev_v = req.resp_valid;
    if (req.resp_valid && req.resp_ready) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_resp: got rdata %h want none",
                 req.resp_rdata);
      end else begin
        me = q.pop_front();
        chk("resp_rdata", req.resp_rdata, me.rdata);
        chk("resp_fault", {31'b0, req.resp_fault}, {31'b0, me.fault});
        chk("latency", 32'(rise_cyc - acc_cyc), 32'(me.lat));
      end
      done_cnt++;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic poke(input logic [7:0] i, input logic [7:0] v);
    poke_i  = i;
    poke_v  = v;
    poke_en = 1'b1;
    step();
    poke_en = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (!req.req_ready && k < 20) begin
      step();
      k++;
    end
  endtask

  task automatic drive(input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    req.req_store  = st;
    req.req_funct3 = f3;
    req.req_addr   = a;
    req.req_wdata  = wd;
    req.req_valid  = 1'b1;
    step();
    req.req_valid  = 1'b0;
  endtask

  task automatic do_req(input string nm, input logic st,
                        input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] erd,
                        input logic ef, input int lat, input int nacc,
                        input logic [2:0] esz, input logic split);
    int   w0, d0, k;
    exp_t e;
    e.rdata = erd;
    e.fault = ef;
    e.lat   = lat;
    wait_idle();
    q.push_back(e);
    w0 = wr_cnt;
    d0 = done_cnt;
    drive(st, f3, a, wd);
    for (int i = 0; i < nacc; i++) begin
      chk({nm, "_addr"}, mem.mem_address, a + (split ? 32'(i) : 32'd0));
      chk({nm, "_size"}, {29'b0, mem.mem_access_size}, {29'b0, esz});
      chk({nm, "_we"}, {31'b0, mem.mem_read_write}, {31'b0, st});
      step();
    end
    k = 0;
    while (done_cnt == d0 && k < 20) begin
      step();
      k++;
    end
    if (done_cnt == d0) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got no response want one", nm);
    end
    chk({nm, "_writes"}, 32'(wr_cnt - w0), st ? 32'(nacc) : 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int w0, d0;
    exp_t e;
    req.req_valid  = 1'b0;
    req.req_store  = 1'b0;
    req.req_funct3 = '0;
    req.req_addr   = '0;
    req.req_wdata  = '0;
    req.resp_ready = 1'b1;
    step();
    step();
    clr = 1'b0;
    chk("rst_req_ready", {31'b0, req.req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, req.resp_valid}, 32'd0);
    chk("rst_rdata", req.resp_rdata, 32'd0);
    chk("rst_fault", {31'b0, req.resp_fault}, 32'd0);
    chk("rst_we", {31'b0, mem.mem_read_write}, 32'd0);
    chk("rst_addr", mem.mem_address, BASE);
    chk("rst_size", {29'b0, mem.mem_access_size}, 32'd0);
    chk("rst_din", mem.mem_data_in, 32'd0);
    reset = 1'b0;

    poke(8'h10, 8'hBB); poke(8'h11, 8'hAA);
    poke(8'h12, 8'h99); poke(8'h13, 8'h88);
    poke(8'h20, 8'h11); poke(8'h21, 8'h22);
    poke(8'h22, 8'h33); poke(8'h23, 8'h44);
    poke(8'h30, 8'h5A); poke(8'h60, 8'hF0);

    do_req("lw_al", 0, LW, BASE + 32'h10, 0, 32'h8899AABB, 0, 2, 1,
           3'b010, 0);
    do_req("lh_mis", 0, LH, BASE + 32'h21, 0, 32'h00003322, 0, 3, 2,
           3'b100, 1);
    poke(8'h22, 8'h80);
    do_req("lh_neg", 0, LH, BASE + 32'h21, 0, 32'hFFFF8022, 0, 3, 2,
           3'b100, 1);
    do_req("lhu_mis", 0, LHU, BASE + 32'h21, 0, 32'h00008022, 0, 3, 2,
           3'b100, 1);
    do_req("sw_mis", 1, SW, BASE + 32'h31, 32'hDEADBEEF, 0, 0, 5, 4,
           3'b100, 1);
    do_req("lw_back", 0, LW, BASE + 32'h30, 0, 32'hADBEEF5A, 0, 2, 1,
           3'b010, 0);
    chk("byte_34", {24'b0, rb(BASE + 32'h34)}, 32'h000000DE);
    do_req("f_low", 0, LW, 32'h00FFFFFC, 0, 0, 1, 1, 0, 3'b000, 0);
    do_req("f_high", 0, LW, BASE + DEPTH - 2, 0, 0, 1, 1, 0, 3'b000, 0);
    do_req("f_f3", 0, 3'b011, BASE + 32'h10, 0, 0, 1, 1, 0, 3'b000, 0);
    do_req("f_sbu", 1, 3'b100, BASE + 32'h10, 32'h55, 0, 1, 1, 0,
           3'b000, 0);
    do_req("f_lwu", 0, 3'b110, BASE + 32'h10, 0, 0, 1, 1, 0, 3'b000, 0);
    do_req("lb_top", 0, LB, BASE + DEPTH - 1, 0, 0, 0, 2, 1, 3'b000, 0);
    do_req("lw_top", 0, LW, BASE + DEPTH - 4, 0, 0, 0, 2, 1, 3'b010, 0);
    do_req("sw_al", 1, SW, BASE + 32'h40, 32'h12345678, 0, 0, 2, 1,
           3'b010, 0);
    do_req("lbu_al", 0, LBU, BASE + 32'h41, 0, 32'h00000056, 0, 2, 1,
           3'b100, 0);
    do_req("lb_al", 0, LB, BASE + 32'h43, 0, 32'h00000012, 0, 2, 1,
           3'b000, 0);
    do_req("sh_mis", 1, SH, BASE + 32'h45, 32'h0000A5C3, 0, 0, 3, 2,
           3'b100, 1);
    do_req("lhu_back", 0, LHU, BASE + 32'h45, 0, 32'h0000A5C3, 0, 3, 2,
           3'b100, 1);

    // reset lands on the third byte of a split store
    wait_idle();
    w0 = wr_cnt;
    drive(1, SW, BASE + 32'h51, 32'hCAFEBABE);
    step();
    step();
    reset = 1'b1;
    #1;
    chk("rst_mid_we", {31'b0, mem.mem_read_write}, 32'd0);
    @(posedge clock);
    #1;
    chk("rst_mid_ready", {31'b0, req.req_ready}, 32'd1);
    chk("rst_mid_valid", {31'b0, req.resp_valid}, 32'd0);
    chk("rst_mid_addr", mem.mem_address, BASE);
    reset = 1'b0;
    chk("rst_mid_writes", 32'(wr_cnt - w0), 32'd2);
    chk("rst_b51", {24'b0, rb(BASE + 32'h51)}, 32'h000000BE);
    chk("rst_b52", {24'b0, rb(BASE + 32'h52)}, 32'h000000BA);
    chk("rst_b53", {24'b0, rb(BASE + 32'h53)}, 32'h00000000);
    chk("rst_b54", {24'b0, rb(BASE + 32'h54)}, 32'h00000000);

    // response back-pressure with a competing request held high
    wait_idle();
    req.resp_ready = 1'b0;
    e.rdata = 32'hFFFFFFF0;
    e.fault = 1'b0;
    e.lat   = 2;
    q.push_back(e);
    d0 = done_cnt;
    drive(0, LB, BASE + 32'h60, 0);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", {31'b0, req.resp_valid}, 32'd1);
      chk("hold_rdata", req.resp_rdata, 32'hFFFFFFF0);
      chk("hold_ready", {31'b0, req.req_ready}, 32'd0);
      req.req_store  = 1'b0;
      req.req_funct3 = LW;
      req.req_addr   = BASE + 32'h10;
      req.req_valid  = 1'b1;
      step();
    end
    req.req_valid  = 1'b0;
    req.resp_ready = 1'b1;
    step();
    chk("hold_done", 32'(done_cnt - d0), 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("hold_ignored", {31'b0, req.resp_valid}, 32'd0);
      step();
    end

    do_req("lw_final", 0, LW, BASE + 32'h10, 0, 32'h8899AABB, 0, 2, 1,
           3'b010, 0);
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
